// File: rtl/vdc_pkg.sv
// Shared types and constants for the VDC CRTC raster timing generator.
package vdc_pkg;

  typedef logic [7:0] vdc_char_t;
  typedef logic [4:0] vdc_line_t;
  typedef logic [3:0] vdc_nib_t;

  typedef enum logic {VS_ACTIVE = 1'b0, VS_ADJUST = 1'b1} vstate_t;

  localparam int SYNC_W_ZERO = 16;

  // A programmed width of 0 is either the maximum pulse or no pulse at all.
  function automatic logic [4:0] sync_width(input vdc_nib_t w, input bit zero_is_16);
    if (w == 4'd0) return zero_is_16 ? 5'(SYNC_W_ZERO) : 5'd0;
    return {1'b0, w};
  endfunction

endpackage

// File: rtl/vdc_sync_pulse.sv
// Non-retriggerable sync pulse: starts on 'start', lasts 'width' occurrences of 'step'.
module vdc_sync_pulse
  import vdc_pkg::*;
#(
  parameter bit ZERO_IS_16 = 1'b1
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     start,
  input  logic     step,
  input  vdc_nib_t width,
  output logic     out
);

  logic       active_q, active_d;
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] width_eff;

  assign width_eff = sync_width(width, ZERO_IS_16);

  // Width is compared with >= so a width lowered mid-pulse ends it at the next step.
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    if (active_q) begin
      if (step) begin
        if (({1'b0, cnt_q} + 6'd1) >= {1'b0, width_eff}) begin
          active_d = 1'b0;
          cnt_d    = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
    end else if (start && (width_eff != 5'd0)) begin
      active_d = 1'b1;
      cnt_d    = 5'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      cnt_q    <= 5'd0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out = active_q;

endmodule

// File: rtl/vdc_crtc_timing.sv
// VDC CRTC raster timing: counters, display windows and syncs, advancing on the pixel enable.
// Optional interlace support is compiled in with the VDC_INTERLACE_EN macro.
module vdc_crtc_timing
  import vdc_pkg::*;
#(
  parameter int HSW_ZERO_IS_16 = 1
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      enable,
  input  vdc_char_t reg_ht,
  input  vdc_char_t reg_hd,
  input  vdc_char_t reg_hp,
  input  vdc_nib_t  reg_hw,
  input  vdc_nib_t  reg_vw,
  input  vdc_char_t reg_vt,
  input  vdc_line_t reg_va,
  input  vdc_char_t reg_vd,
  input  vdc_char_t reg_vp,
  input  vdc_line_t reg_ctv,
  input  vdc_nib_t  reg_cth,
  input  logic [1:0] reg_im,
  output vdc_char_t col,
  output vdc_char_t row,
  output vdc_line_t line,
  output vdc_nib_t  pixel,
  output logic      hDisp,
  output logic      vDisp,
  output logic      hSync,
  output logic      vSync,
  output logic      newLine,
  output logic      newFrame,
  output logic      field
);

  vdc_nib_t  pixel_q, pixel_d;
  vdc_char_t col_q, col_d, row_q, row_d;
  vdc_line_t line_q, line_d;
  vstate_t   vstate_q, vstate_d;
  logic      hdisp_q, hdisp_d, vdisp_q, vdisp_d;
  logic      newline_q, newframe_q;
  logic      field_q, field_d;
  logic      char_tick, line_end, frame_end;
  logic      odd_field;
  vdc_char_t vs_col;
  logic      hs_start, vs_mark, vs_start;
  logic      unused_im;

  assign unused_im = ^reg_im;

`ifdef VDC_INTERLACE_EN
  assign odd_field = field_q;
`else
  assign odd_field = 1'b0;
`endif

  always_comb begin
    char_tick = enable && (pixel_q >= reg_cth);
    line_end  = char_tick && (col_q >= reg_ht);
    pixel_d   = pixel_q;
    col_d     = col_q;
    row_d     = row_q;
    line_d    = line_q;
    vstate_d  = vstate_q;
    frame_end = 1'b0;
    if (enable) pixel_d = char_tick ? 4'd0 : pixel_q + 4'd1;
    if (char_tick) col_d = line_end ? 8'd0 : col_q + 8'd1;
    if (line_end) begin
      case (vstate_q)
        VS_ACTIVE: begin
          if (line_q >= reg_ctv) begin
            line_d = 5'd0;
            if (row_q >= reg_vt) begin
              if ((reg_va != 5'd0) || odd_field) begin
                vstate_d = VS_ADJUST;
              end else begin
                row_d     = 8'd0;
                frame_end = 1'b1;
              end
            end else begin
              row_d = row_q + 8'd1;
            end
          end else begin
            line_d = line_q + 5'd1;
          end
        end
        default: begin
          // The odd field stretches the adjust zone by one scanline.
          if (({1'b0, line_q} + 6'd1) >= ({1'b0, reg_va} + {5'd0, odd_field})) begin
            line_d    = 5'd0;
            row_d     = 8'd0;
            vstate_d  = VS_ACTIVE;
            frame_end = 1'b1;
          end else begin
            line_d = line_q + 5'd1;
          end
        end
      endcase
    end
`ifdef VDC_INTERLACE_EN
    field_d = field_q ^ (frame_end & reg_im[0]);
`else
    field_d = 1'b0;
`endif
    hdisp_d = (col_d < reg_hd);
    vdisp_d = (row_d < reg_vd) && (vstate_d == VS_ACTIVE);
  end

  // Odd-field vsync start and width steps are shifted to the half-line column.
  assign vs_col   = odd_field ? (reg_ht >> 1) : 8'd0;
  assign vs_mark  = char_tick && (col_d == vs_col);
  assign vs_start = vs_mark && (vstate_d == VS_ACTIVE) && (row_d == reg_vp) && (line_d == 5'd0);
  assign hs_start = char_tick && (col_d == reg_hp);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_q    <= 4'd0;
      col_q      <= 8'd0;
      row_q      <= 8'd0;
      line_q     <= 5'd0;
      vstate_q   <= VS_ACTIVE;
      field_q    <= 1'b0;
      hdisp_q    <= 1'b0;
      vdisp_q    <= 1'b0;
      newline_q  <= 1'b0;
      newframe_q <= 1'b0;
    end else begin
      pixel_q    <= pixel_d;
      col_q      <= col_d;
      row_q      <= row_d;
      line_q     <= line_d;
      vstate_q   <= vstate_d;
      field_q    <= field_d;
      newline_q  <= line_end;
      newframe_q <= frame_end;
      if (enable) begin
        hdisp_q <= hdisp_d;
        vdisp_q <= vdisp_d;
      end
    end
  end

  vdc_sync_pulse #(.ZERO_IS_16(HSW_ZERO_IS_16 != 0)) u_hsync (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (hs_start),
    .step    (char_tick),
    .width   (reg_hw),
    .out     (hSync)
  );

  vdc_sync_pulse #(.ZERO_IS_16(1'b1)) u_vsync (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (vs_start),
    .step    (vs_mark),
    .width   (reg_vw),
    .out     (vSync)
  );

  assign col      = col_q;
  assign row      = row_q;
  assign line     = line_q;
  assign pixel    = pixel_q;
  assign hDisp    = hdisp_q;
  assign vDisp    = vdisp_q;
  assign newLine  = newline_q;
  assign newFrame = newframe_q;
  assign field    = field_q;

endmodule

// File: tb/tb_vdc_crtc_timing.sv
// Directed bench for vdc_crtc_timing with hand-computed raster timings.
module tb_vdc_crtc_timing;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] reg_ht, reg_hd, reg_hp, reg_vt, reg_vd, reg_vp;
  logic [3:0] reg_hw, reg_vw, reg_cth;
  logic [4:0] reg_va, reg_ctv;
  logic [1:0] reg_im;
  logic [7:0] col, row;
  logic [4:0] line;
  logic [3:0] pixel;
  logic       hDisp, vDisp, hSync, vSync, newLine, newFrame, field;

  int n_assert = 0;
  int n_fail   = 0;

  vdc_crtc_timing dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .reg_ht(reg_ht), .reg_hd(reg_hd), .reg_hp(reg_hp), .reg_hw(reg_hw), .reg_vw(reg_vw),
    .reg_vt(reg_vt), .reg_va(reg_va), .reg_vd(reg_vd), .reg_vp(reg_vp), .reg_ctv(reg_ctv),
    .reg_cth(reg_cth), .reg_im(reg_im),
    .col(col), .row(row), .line(line), .pixel(pixel),
    .hDisp(hDisp), .vDisp(vDisp), .hSync(hSync), .vSync(vSync),
    .newLine(newLine), .newFrame(newFrame), .field(field)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic wait_nl(input string tag, input int lim);
    int k;
    k = 0;
    while (newLine !== 1'b1 && k < lim) begin step(); k++; end
    chk(tag, {31'd0, newLine}, 32'd1);
  endtask

  task automatic wait_nf(input string tag, input int lim);
    int k;
    k = 0;
    while (newFrame !== 1'b1 && k < lim) begin step(); k++; end
    chk(tag, {31'd0, newFrame}, 32'd1);
  endtask

  task automatic set_fast_vert();
    reg_cth = 4'd0; reg_ht = 8'd3; reg_hd = 8'd2; reg_hp = 8'd1; reg_hw = 4'd1;
    reg_ctv = 5'd7; reg_vt = 8'd32; reg_vd = 8'd25; reg_va = 5'd0; reg_vp = 8'd29; reg_vw = 4'd4;
  endtask

  initial begin
    int hd_c, hs_c, hs_rise, nl_at, vd_c, vs_c, vs_row, vs_line, vs_col, nf_at;
    int bad, lastl, k, n, saw;
    logic [7:0] c_hold;
    logic [3:0] p_hold;

    reg_im = 2'd0;
    reg_cth = 4'd7; reg_ht = 8'd126; reg_hd = 8'd80; reg_hp = 8'd102; reg_hw = 4'd9;
    reg_ctv = 5'd7; reg_vt = 8'd32; reg_vd = 8'd25; reg_va = 5'd0; reg_vp = 8'd29; reg_vw = 4'd4;
    enable = 1'b1;

    // Reset state
    step();
    chk("reset_counters", {8'd0, col, row, line, pixel, 3'd0}, 32'd0);
    chk("reset_flags", {25'd0, hDisp, vDisp, hSync, vSync, newLine, newFrame, field}, 32'd0);

    // 80-column horizontal timing
    do_reset();
    wait_nl("h_first_nl", 1100);
    chk("h_col_at_nl", {24'd0, col}, 32'd0);
    hd_c = 0; hs_c = 0; hs_rise = -1; nl_at = -1;
    for (int t = 0; t < 1016; t++) begin
      if (hDisp) hd_c++;
      if (hSync) begin hs_c++; if (hs_rise < 0) hs_rise = t; end
      if (t > 0 && newLine && nl_at < 0) nl_at = t;
      step();
    end
    chk("h_period", {31'd0, newLine}, 32'd1);
    chk("h_no_early_nl", nl_at, -1);
    chk("h_disp_len", hd_c, 640);
    chk("h_sync_rise", hs_rise, 816);
    chk("h_sync_len", hs_c, 72);

    enable = 1'b0;
    c_hold = col; p_hold = pixel;
    repeat (5) step();
    chk("hold_col", {24'd0, col}, {24'd0, c_hold});
    chk("hold_pixel", {28'd0, pixel}, {28'd0, p_hold});
    enable = 1'b1;

    // 25-row vertical timing, 4 enables per scanline
    set_fast_vert();
    do_reset();
    wait_nf("v_first_nf", 1200);
    chk("v_nl_with_nf", {31'd0, newLine}, 32'd1);
    vd_c = 0; vs_c = 0; vs_row = -1; vs_line = -1; vs_col = -1; nf_at = -1;
    for (int t = 0; t < 1056; t++) begin
      if (vDisp) vd_c++;
      if (vSync) begin
        vs_c++;
        if (vs_row < 0) begin vs_row = row; vs_line = line; vs_col = col; end
      end
      if (t > 0 && newFrame && nf_at < 0) nf_at = t;
      step();
    end
    chk("v_period", {31'd0, newFrame}, 32'd1);
    chk("v_no_early_nf", nf_at, -1);
    chk("v_disp_cycles", vd_c, 800);
    chk("v_sync_cycles", vs_c, 16);
    chk("v_sync_row", vs_row, 29);
    chk("v_sync_line", vs_line, 0);
    chk("v_sync_col", vs_col, 0);

    // Adjust zone: 4 rows of 2 lines plus 5 adjust lines
    reg_vt = 8'd3; reg_ctv = 5'd1; reg_va = 5'd5; reg_vd = 8'd2; reg_vp = 8'd200;
    do_reset();
    wait_nf("adj_first_nf", 300);
    chk("adj_vdisp_row0", {31'd0, vDisp}, 32'd1);
    bad = 0; lastl = -1; nf_at = -1;
    for (int t = 0; t < 52; t++) begin
      if (t % 4 == 0 && t / 4 >= 8) begin
        if (line !== 5'(t / 4 - 8) || vDisp !== 1'b0) bad++;
        lastl = line;
      end
      if (t > 0 && newFrame && nf_at < 0) nf_at = t;
      step();
    end
    chk("adj_frame_len", {31'd0, newFrame}, 32'd1);
    chk("adj_no_early_nf", nf_at, -1);
    chk("adj_line_vdisp", bad, 0);
    chk("adj_last_line", lastl, 4);

    // Horizontal total lowered below the current column
    set_fast_vert();
    reg_ht = 8'd126; reg_hd = 8'd80; reg_hp = 8'd200;
    do_reset();
    repeat (100) step();
    chk("lower_col100", {24'd0, col}, 32'd100);
    reg_ht = 8'd50;
    step();
    chk("lower_wrap_col", {24'd0, col}, 32'd0);
    chk("lower_wrap_nl", {31'd0, newLine}, 32'd1);
    step();
    chk("lower_nl_single", {31'd0, newLine}, 32'd0);
    chk("lower_col1", {24'd0, col}, 32'd1);
    k = 1;
    while (newLine !== 1'b1 && k < 300) begin step(); k++; end
    chk("lower_period", k, 51);

    // Zero hsync width across the line wrap
    reg_ht = 8'd20; reg_hp = 8'd20; reg_hw = 4'd0;
    do_reset();
    n = 0;
    while (hSync !== 1'b1 && n < 100) begin step(); n++; end
    chk("hw0_rise_col", {24'd0, col}, 32'd20);
    n = 0; saw = 0;
    while (hSync === 1'b1 && n < 40) begin
      if (newLine) saw = 1;
      n++;
      step();
    end
    chk("hw0_len", n, 16);
    chk("hw0_spans_wrap", saw, 1);

    // Reset in the middle of a frame
    set_fast_vert();
    do_reset();
    n = 0;
    while (row !== 8'd10 && n < 2000) begin step(); n++; end
    chk("mr_reach_row10", {24'd0, row}, 32'd10);
    reset_n = 1'b0;
    #1;
    chk("mr_counters", {8'd0, col, row, line, pixel, 3'd0}, 32'd0);
    chk("mr_flags", {25'd0, hDisp, vDisp, hSync, vSync, newLine, newFrame, field}, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    chk("mr_restart_pos", {8'd0, col, row, line, pixel, 3'd0}, {8'd0, 8'd1, 8'd0, 5'd0, 4'd0, 3'd0});
    chk("mr_restart_disp", {30'd0, hDisp, vDisp}, 32'd3);

`ifdef VDC_INTERLACE_EN
    // Interlaced fields: odd field delays vsync by half a line and adds a scanline
    reg_im = 2'd1; reg_cth = 4'd0; reg_ht = 8'd126; reg_hd = 8'd80; reg_hp = 8'd200; reg_hw = 4'd1;
    reg_ctv = 5'd0; reg_vt = 8'd3; reg_va = 5'd0; reg_vd = 8'd4; reg_vp = 8'd1; reg_vw = 4'd1;
    do_reset();
    wait_nf("il_first_nf", 600);
    chk("il_field_odd", {31'd0, field}, 32'd1);
    vs_row = -1; vs_col = -1; n = 0;
    step(); n++;
    while (newFrame !== 1'b1 && n < 1000) begin
      if (vSync && vs_row < 0) begin vs_row = row; vs_col = col; end
      step(); n++;
    end
    chk("il_odd_frame_len", n, 635);
    chk("il_vs_col", vs_col, 63);
    chk("il_vs_row", vs_row, 1);
    chk("il_field_even", {31'd0, field}, 32'd0);
`else
    // Interlace mode has no effect without the interlace build
    reg_im = 2'd3;
    set_fast_vert();
    do_reset();
    wait_nf("noil_nf1", 1200);
    chk("noil_field1", {31'd0, field}, 32'd0);
    step();
    wait_nf("noil_nf2", 1200);
    chk("noil_field2", {31'd0, field}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
